// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns / InvMixColumns, one column per cycle, 4-cycle latency.
// Results from columns 0..2 accumulate in a shift register; column 3 completes the word.
module mix_columns (
    input  logic         clk,
    input  logic         g_rst,
    input  logic         enable,
    input  logic         inv,
    input  logic [127:0] data_in,
    output logic [127:0] data_mixed,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;
    logic         inv_q, inv_d;
    logic [95:0]  res_q, res_d;
    logic [127:0] out_q, out_d;
    logic         done_q, done_d;
    logic [31:0]  mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using the xtime chain 2, 4, 8.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] c, input logic m);
        logic [7:0] a [4];
        logic [7:0] o [4];
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        for (int r = 0; r < 4; r++)
            o[r] = m ? gmul(a[r], 4'he) ^ gmul(a[(r+1)%4], 4'hb) ^ gmul(a[(r+2)%4], 4'hd) ^ gmul(a[(r+3)%4], 4'h9)
                     : gmul(a[r], 4'h2) ^ gmul(a[(r+1)%4], 4'h3) ^ a[(r+2)%4] ^ a[(r+3)%4];
        return {o[0], o[1], o[2], o[3]};
    endfunction

    assign mixed = mix(data_q[127:96], inv_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        inv_d   = inv_q;
        res_d   = res_q;
        out_d   = out_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (enable) begin
                data_d  = data_in;
                inv_d   = inv;
                col_d   = 2'd0;
                state_d = RUN;
            end
        end else begin
            data_d = data_q << 32;
            res_d  = {res_q[63:0], mixed};
            col_d  = col_q + 2'd1;
            if (col_q == 2'd3) begin
                out_d   = {res_q, mixed};
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (g_rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            data_q  <= '0;
            inv_q   <= 1'b0;
            res_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign data_mixed = out_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns: directed vectors with hand-computed results for mix_columns.
module tb_mix_columns;
    logic         clk = 1'b0;
    logic         g_rst, enable, inv;
    logic [127:0] data_in;
    logic [127:0] data_mixed;
    logic         busy, done;
    int           n_vec = 0;
    int           n_err = 0;

    localparam logic [127:0] ENC_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] ENC_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] RED_IN  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] RED_OUT = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;

    mix_columns dut (
        .clk        (clk),
        .g_rst      (g_rst),
        .enable     (enable),
        .inv        (inv),
        .data_in    (data_in),
        .data_mixed (data_mixed),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string tag, input logic [127:0] d, input logic m,
                             input logic [127:0] exp, input bit disturb);
        data_in = d;
        inv     = m;
        enable  = 1'b1;
        tick();
        enable = 1'b0;
        check({tag, " start"}, 128'({busy, done}), 128'b10);
        for (int i = 1; i <= 4; i++) begin
            if (disturb) begin
                inv     = ~inv;
                data_in = ~data_in;
                enable  = 1'b1;
            end
            tick();
            check($sformatf("%s bd%0d", tag, i), 128'({busy, done}), i == 4 ? 128'b01 : 128'b10);
        end
        enable = 1'b0;
        check({tag, " data"}, data_mixed, exp);
        tick();
        check({tag, " hold"}, {data_mixed[126:0], done}, {exp[126:0], 1'b0});
    endtask

    initial begin
        g_rst   = 1'b1;
        enable  = 1'b1;
        inv     = 1'b0;
        data_in = ENC_IN;
        tick();
        tick();
        check("rst data", data_mixed, '0);
        check("rst bd", 128'({busy, done}), 128'b00);
        g_rst  = 1'b0;
        enable = 1'b0;
        tick();
        check("idle bd", 128'({busy, done}), 128'b00);

        run_block("enc", ENC_IN, 1'b0, ENC_OUT, 1'b0);
        run_block("dec", ENC_OUT, 1'b1, ENC_IN, 1'b0);
        run_block("red", RED_IN, 1'b0, RED_OUT, 1'b0);
        run_block("latch", ENC_IN, 1'b0, ENC_OUT, 1'b1);
        run_block("latch inv", ENC_OUT, 1'b1, ENC_IN, 1'b1);

        // enable held high: second start at N+5 with data changed during the first block
        data_in = ENC_IN;
        inv     = 1'b0;
        enable  = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 1) data_in = RED_IN;
            check($sformatf("hold e%0d", e), 128'({busy, done}),
                  (e == 4 || e == 9) ? 128'b01 : 128'b10);
            if (e == 4) check("hold first", data_mixed, ENC_OUT);
            if (e == 9) check("hold second", data_mixed, RED_OUT);
        end
        enable = 1'b0;
        tick();
        check("hold idle", 128'({busy, done}), 128'b00);

        // reset at edge N+2 of an active block
        data_in = ENC_IN;
        inv     = 1'b0;
        enable  = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        check("midrst bd", 128'({busy, done}), 128'b00);
        check("midrst data", data_mixed, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("midrst quiet%0d", k), {data_mixed[126:0], done, busy}, '0);
        end
        run_block("post rst", ENC_OUT, 1'b1, ENC_IN, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mix_columns.md
MIX_COLUMNS -- requirements
Module: mix_columns

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 g_rst  input  1  reset, synchronous and active-high.
REQ-004 enable  input  1  start request, sampled only while idle.
REQ-005 inv  input  1  mode select: 0 = MixColumns (encrypt), 1 = InvMixColumns (decrypt).
REQ-006 data_in  input  128  AES state from the ShiftRows stage, sampled with enable.
REQ-007 data_mixed  output  128  registered result.
REQ-008 busy  output  1  high while a block is in progress.
REQ-009 done  output  1  one-cycle completion pulse.

Function
REQ-010 State layout SHALL be column-major:
- column c occupies data[127-32c : 96-32c];
- row 0 is the MSB byte of each column.
REQ-011 Each column (a0..a3) SHALL be multiplied in GF(2^8), polynomial 0x11B:
- inv=0: circulant matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02};
- inv=1: circulant matrix rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
REQ-012 xtime SHALL be a shift left by 1, XOR 0x1B when the shifted-out bit is 1; results SHALL be 8-bit with no overflow.
REQ-013 The FSM SHALL have two states, IDLE and RUN, with a 2-bit column counter col.
REQ-014 IDLE with enable=1 at edge N SHALL:
- capture data_in and inv into internal registers;
- clear col to 0;
- set busy=1 and enter RUN.
REQ-015 RUN SHALL process exactly one column per cycle: column col at edges N+1..N+4, with col incrementing each edge.
REQ-016 At edge N+4 (col=3) the block SHALL:
- load all four mixed columns into data_mixed in one update;
- set done=1 and busy=0;
- return to IDLE.
REQ-017 Latency SHALL be 4 cycles from the enable-sampling edge to done.
REQ-018 Minimum issue interval SHALL be 5 cycles: an enable sampled at edge N+5 starts the next block.
REQ-019 done SHALL be high for exactly one cycle per accepted block.
REQ-020 enable sampled while busy=1 SHALL be ignored:
- no restart, no queuing;
- data_in and inv changes during RUN SHALL NOT affect the result.
REQ-021 data_mixed SHALL hold its value between completions and change only at a completion edge or at reset.
REQ-022 In IDLE with enable=0, all outputs SHALL hold, except that done SHALL be 0.

Reset
REQ-023 g_rst=1 at a rising edge SHALL set:
- data_mixed = 128'h0, done = 0, busy = 0;
- state = IDLE, col = 0;
- internal registers = 0.
REQ-024 Reset SHALL take priority over enable and over an in-progress block.
REQ-025 A block interrupted by reset SHALL produce no done and SHALL leave data_mixed = 0.
REQ-026 enable asserted together with g_rst SHALL be discarded; the first start is the first enable sampled with g_rst=0.

Verification
REQ-027 Encrypt vector:
- stimulus: inv=0, data_in = db135345_f20a225c_01010101_2d26314c, enable pulse at edge N;
- response: done high only after edge N+4; data_mixed = 8e4da1bc_9fdc589d_01010101_4d7ebdf8; busy high for edges N..N+3.
REQ-028 Decrypt vector:
- stimulus: inv=1, data_in = 8e4da1bc_9fdc589d_01010101_4d7ebdf8;
- response: data_mixed = db135345_f20a225c_01010101_2d26314c after 4 cycles.
REQ-029 Reduction edge case:
- stimulus: inv=0, data_in = c6c6c6c6_d4d4d4d5_00000000_ffffffff;
- response: data_mixed = c6c6c6c6_d5d5d7d6_00000000_ffffffff.
REQ-030 Ignore-while-busy:
- stimulus: enable held high continuously from edge N, with data_in changed at N+2;
- response: first result uses the N-captured data; second start at N+5; done at N+4 and N+9 only.
REQ-031 Reset mid-block:
- stimulus: g_rst at edge N+2 of an active block;
- response: busy=0, done stays 0, data_mixed = 0; a fresh enable afterwards completes normally.
REQ-032 Mode latch:
- stimulus: inv toggled during RUN;
- response: result matches the inv value captured at the start edge.
